// File: rtl/hp_fp_pkg.sv
// Shared half-precision field layout, exception codes and divider FSM states.
// Imported by the divider top and its restoring-step datapath.
package hp_fp_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int HP_W  = 1 + EXP_W + MAN_W;

  // Significand with hidden bit, partial remainder with two guard bits, quotient with one extra integer bit.
  localparam int SIG_W     = MAN_W + 1;
  localparam int REM_W     = SIG_W + 2;
  localparam int QUO_W     = SIG_W + 1;
  localparam int DIV_STEPS = QUO_W;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_DIVZ = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  function automatic logic get_sign(input logic [HP_W-1:0] x);
    return x[HP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] get_exp(input logic [HP_W-1:0] x);
    return x[EXP_W+MAN_W-1:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] get_man(input logic [HP_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Subnormals are flushed, so a zero exponent alone marks a zero operand.
  function automatic logic is_zero(input logic [HP_W-1:0] x);
    return (get_exp(x) == '0);
  endfunction

endpackage

// File: rtl/hp_div_step.sv
// One radix-2 restoring division step: conditional subtract, then shift the
// partial remainder left for the next quotient bit.
module hp_div_step
  import hp_fp_pkg::*;
(
  input  logic [REM_W-1:0] r,
  input  logic [SIG_W-1:0] d,
  output logic [REM_W-1:0] r_next,
  output logic             qbit
);

  logic [REM_W-1:0] d_ext;
  logic [REM_W-1:0] diff;

  assign d_ext  = {2'b00, d};
  assign qbit   = (r >= d_ext);
  assign diff   = qbit ? (r - d_ext) : r;
  assign r_next = diff << 1;

endmodule

// File: rtl/hp_divider.sv
// Sequential half-precision divider: quotient = A / B, one quotient bit per
// clock, truncating, with start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured and classified on start
// DIV   | 12 restoring steps, one quotient bit per cycle
// NORM  | normalise, range-check exponent, register result, pulse done
module hp_divider
  import hp_fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [HP_W-1:0] A,
  input  logic [HP_W-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [HP_W-1:0] quotient,
  output logic [1:0]      exceptions
);

  localparam logic signed [7:0] BIAS_S = 8'(BIAS);
  localparam logic [3:0]        LAST_STEP = 4'(DIV_STEPS - 1);

  state_t           state_q, state_d;
  logic [REM_W-1:0] r_q, r_d;
  logic [SIG_W-1:0] d_q, d_d;
  logic [QUO_W-1:0] q_q, q_d;
  logic [3:0]       count_q, count_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic             sign_q, sign_d;
  logic             divz_q, divz_d;
  logic             zero_q, zero_d;
  logic             done_d;
  logic [HP_W-1:0]  quotient_d;
  logic [1:0]       exceptions_d;

  logic [REM_W-1:0] r_step;
  logic             qbit;
  logic signed [7:0] e_calc;
  logic [MAN_W-1:0] man_norm;

  hp_div_step u_step (
    .r      (r_q),
    .d      (d_q),
    .r_next (r_step),
    .qbit   (qbit)
  );

  // A quotient below 1.0 leaves its leading one at q[10], costing one exponent.
  always_comb begin
    e_calc   = $signed({3'b000, exp_a_q}) - $signed({3'b000, exp_b_q}) + BIAS_S
             - (q_q[QUO_W-1] ? 8'sd0 : 8'sd1);
    man_norm = q_q[QUO_W-1] ? q_q[MAN_W:1] : q_q[MAN_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    d_d          = d_q;
    q_d          = q_q;
    count_d      = count_q;
    exp_a_d      = exp_a_q;
    exp_b_d      = exp_b_q;
    sign_d       = sign_q;
    divz_d       = divz_q;
    zero_d       = zero_q;
    done_d       = 1'b0;
    quotient_d   = quotient;
    exceptions_d = exceptions;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = get_sign(A) ^ get_sign(B);
          exp_a_d = get_exp(A);
          exp_b_d = get_exp(B);
          divz_d  = is_zero(B);
          zero_d  = is_zero(A) && !is_zero(B);
          r_d     = {2'b00, 1'b1, get_man(A)};
          d_d     = {1'b1, get_man(B)};
          q_d     = '0;
          count_d = '0;
          state_d = (is_zero(A) || is_zero(B)) ? NORM : DIV;
        end
      end
      DIV: begin
        r_d     = r_step;
        q_d     = {q_q[QUO_W-2:0], qbit};
        count_d = count_q + 4'd1;
        if (count_q == LAST_STEP) state_d = NORM;
      end
      NORM: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (divz_q) begin
          exceptions_d = EXC_DIVZ;
          quotient_d   = '0;
        end else if (zero_q) begin
          exceptions_d = EXC_NONE;
          quotient_d   = {sign_q, {(HP_W-1){1'b0}}};
        end else if (e_calc > 8'sd30) begin
          exceptions_d = EXC_OVF;
          quotient_d   = '0;
        end else if (e_calc < 8'sd1) begin
          exceptions_d = EXC_UNF;
          quotient_d   = '0;
        end else begin
          exceptions_d = EXC_NONE;
          quotient_d   = {sign_q, e_calc[EXP_W-1:0], man_norm};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      count_q    <= '0;
      exp_a_q    <= '0;
      exp_b_q    <= '0;
      sign_q     <= 1'b0;
      divz_q     <= 1'b0;
      zero_q     <= 1'b0;
      done       <= 1'b0;
      quotient   <= '0;
      exceptions <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      q_q        <= q_d;
      count_q    <= count_d;
      exp_a_q    <= exp_a_d;
      exp_b_q    <= exp_b_d;
      sign_q     <= sign_d;
      divz_q     <= divz_d;
      zero_q     <= zero_d;
      done       <= done_d;
      quotient   <= quotient_d;
      exceptions <= exceptions_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/hp_divider.md
Name: hp_divider

Overview:
- Sequential IEEE-754 half-precision divider. Computes quotient = A / B.
- Inverse-operation companion to the team's combinational half-precision multiplier.
- Uses the same field layout and the same exception encoding, extended with a divide-by-zero code.
- Radix-2 restoring division on 11-bit significands, one quotient bit per clock, with a start/done handshake.

Parameters:
- EXP_W, 5: exponent field width.
- MAN_W, 10: stored mantissa width. Hidden bit is implied.
- BIAS, 15: exponent bias.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- A  in  16  dividend {sign, exp[4:0], man[9:0]}.
- B  in  16  divisor, same format.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse; result valid.
- quotient  out  16  result. Held until next done.
- exceptions  out  2  00 valid, 01 overflow, 10 underflow, 11 divide-by-zero. Held with quotient.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, quotient=16'h0000, exceptions=2'b00.
- Reset asserted mid-operation aborts the operation; no done is produced.
- Operand rules:
  - Exponent 0 means the operand is zero; subnormals are flushed to zero.
  - Exponent 31 is treated as an ordinary normal value; there is no Inf/NaN support.
  - Result sign = signA ^ signB.
- FSM states:
  - IDLE: on start=1, capture A and B, then decide:
    - B zero → go to NORM with DIVZ flagged. This takes priority, so 0/0 gives 11.
    - Else A zero → go to NORM with ZERO flagged.
    - Else → go to DIV with R={2'b0,1,manA} (13 bits), D={1,manB}, count=0.
  - DIV, 12 cycles:
    - If R >= {2'b0,D}: qbit=1 and R=R-D; else qbit=0.
    - Then R=R<<1, q={q[10:0],qbit}, count++.
    - After the 12th step, go to NORM.
  - NORM, 1 cycle:
    - If q[11]=1: man=q[10:1], e=expA-expB+BIAS.
    - Else: man=q[9:0], e=expA-expB+BIAS-1.
    - Compute e signed, at least 7 bits.
    - e>30 → exceptions=01, quotient=16'h0000.
    - e<1 → exceptions=10, quotient=16'h0000.
    - DIVZ → exceptions=11, quotient=16'h0000.
    - ZERO → exceptions=00, quotient={sign,15'b0}.
    - Else → exceptions=00, quotient={sign,e[4:0],man}.
    - Register the outputs, set done=1, return to IDLE.
- Rounding: truncation only; remainder discarded.
- Latency:
  - If start is sampled at edge E0, done is high after E13 (normal case) or after E1 (zero/DIVZ case), for exactly one cycle.
  - busy is high from after E0 until the edge that raises done.
- Handshake edge cases:
  - start while busy is ignored; captured operands are unaffected.
  - start in the cycle done is high is accepted (state is IDLE).
  - A and B need only be valid in the start cycle.

Decomposition:
- Package hp_fp_pkg:
  - EXP_W, MAN_W, BIAS.
  - Exception codes EXC_NONE=2'b00, EXC_OVF=2'b01, EXC_UNF=2'b10, EXC_DIVZ=2'b11.
  - State enum {IDLE, DIV, NORM}.
  - Field-extract helper functions.
- One sub-module: hp_div_step. Combinational restoring step, (R[12:0], D[10:0]) → (R_next, qbit).

Test Plan:
- A=16'h4000, B=16'h3C00, start pulse → done 13 cycles later; quotient=16'h4000, exceptions=00; busy high throughout.
- A=16'h3C00, B=16'h4200 (1/3) → quotient=16'h3555, exceptions=00. A=16'hC500, B=16'h4100 → quotient=16'hC000.
- A=16'h3C00, B=16'h0000 → done 1 cycle after start; exceptions=11, quotient=16'h0000. A=16'h0000, B=16'h0000 → exceptions=11. A=16'h8000, B=16'h3C00 → quotient=16'h8000, exceptions=00.
- A=16'h7BFF, B=16'h0400 → exceptions=01, quotient=16'h0000. A=16'h0400, B=16'h7BFF → exceptions=10, quotient=16'h0000.
- Second start with A=16'h3C00, B=16'h4000 during DIV → ignored; first result unchanged. Start asserted in the done cycle → accepted; done 13 cycles later with 16'h3800.
- rst_n low for 1 cycle at DIV count=5 → busy=0, done never pulses, outputs 16'h0000/00. A following start completes normally.
